// File: rtl/cache_pkg.sv
// Shared definitions for the two-level cache slice.
//   - FSM state encoding for cache_hier_param
//   - Hit-level codes reported on resp_level
//   - Word width (64) and byte-offset width (3)
//   - word_align(): clears the byte-offset bits of an address
package cache_pkg;

    localparam int WORD_W   = 64;
    localparam int OFFSET_W = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_L2_LOOK  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    localparam logic [1:0] LVL_L1  = 2'd0;
    localparam logic [1:0] LVL_L2  = 2'd1;
    localparam logic [1:0] LVL_MEM = 2'd2;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// L1 victim way selection (purely combinational).
//   valid  in  WAYS    valid bits of the addressed set
//   ptr    in  WAY_W   round-robin pointer of the addressed set
//   victim out WAY_W   lowest-index invalid way, else ptr
module cache_victim_sel #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] ptr,
    output logic [WAY_W-1:0] victim
);

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        victim = ptr;
        // Scan downwards so the last assignment is the lowest invalid way.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_hier_param.sv
// Two-level cache between the CPU load/store unit and main memory:
// N-way set-associative L1 backed by a direct-mapped L2, 64-bit words,
// write-through with write-allocate, one outstanding memory access.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        CPU request handshake
//   req_write/addr/wdata       request fields (addr bits [2:0] ignored)
//   flush                      invalidate all L1 lines (honoured in IDLE only)
//   resp_valid/rdata/level     one-cycle response; level 0=L1,1=L2,2=memory
//   busy                       FSM not in IDLE
//   mem_req_*                  memory request, held until mem_resp_valid
//   mem_resp_valid/rdata       memory completion pulse and read data
//
// Optional build macro CACHE_PERF_EN adds 32-bit counters l1_hit_cnt,
// l2_hit_cnt and miss_cnt, counting completed requests by resp_level.
module cache_hier_param
    import cache_pkg::*;
#(
    parameter int L1_SETS = 4,
    parameter int L1_WAYS = 2,
    parameter int L2_SETS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [1:0]  resp_level,
    output logic        busy,
    output logic        mem_req_valid,
    output logic        mem_req_write,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0] l1_hit_cnt,
    output logic [31:0] l2_hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int L1_IDX_W = $clog2(L1_SETS);
    localparam int L1_TAG_W = WORD_W - OFFSET_W - L1_IDX_W;
    localparam int L2_IDX_W = $clog2(L2_SETS);
    localparam int L2_TAG_W = WORD_W - OFFSET_W - L2_IDX_W;
    localparam int WAY_W    = (L1_WAYS > 1) ? $clog2(L1_WAYS) : 1;

    // ---------------------------------------------------------------- storage
    logic [L1_WAYS-1:0]  l1_valid [L1_SETS];
    logic [WAY_W-1:0]    l1_ptr   [L1_SETS];
    logic [L1_TAG_W-1:0] l1_tag   [L1_SETS][L1_WAYS];
    logic [WORD_W-1:0]   l1_data  [L1_SETS][L1_WAYS];

    logic [L2_SETS-1:0]  l2_valid;
    logic [L2_TAG_W-1:0] l2_tag  [L2_SETS];
    logic [WORD_W-1:0]   l2_data [L2_SETS];

    state_t             state;
    logic [WORD_W-1:0]  addr_q;
    logic               wr_q;

    // ---------------------------------------------------------------- lookup
    // In IDLE the incoming request is looked up; afterwards the latched one.
    logic [WORD_W-1:0]   lk_addr;
    logic [L1_IDX_W-1:0] l1_idx;
    logic [L1_TAG_W-1:0] l1_tag_in;
    logic [L2_IDX_W-1:0] l2_idx;
    logic [L2_TAG_W-1:0] l2_tag_in;
    logic                l1_hit;
    logic [WAY_W-1:0]    l1_hit_way;
    logic                l2_hit;
    logic [WAY_W-1:0]    victim_way;
    logic [WAY_W-1:0]    ptr_next;
    logic                accept;
    logic                unused_offset_bits;

    assign lk_addr            = (state == S_IDLE) ? req_addr : addr_q;
    assign l1_idx             = lk_addr[OFFSET_W +: L1_IDX_W];
    assign l1_tag_in          = lk_addr[WORD_W-1 -: L1_TAG_W];
    assign l2_idx             = lk_addr[OFFSET_W +: L2_IDX_W];
    assign l2_tag_in          = lk_addr[WORD_W-1 -: L2_TAG_W];
    assign unused_offset_bits = ^lk_addr[OFFSET_W-1:0];

    assign l2_hit   = l2_valid[l2_idx] && (l2_tag[l2_idx] == l2_tag_in);
    assign ptr_next = WAY_W'((int'(l1_ptr[l1_idx]) + 1) % L1_WAYS);

    assign req_ready = (state == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != S_IDLE);

    always_comb begin
        l1_hit     = 1'b0;
        l1_hit_way = '0;
        for (int w = 0; w < L1_WAYS; w++) begin
            if (l1_valid[l1_idx][w] && (l1_tag[l1_idx][w] == l1_tag_in)) begin
                l1_hit     = 1'b1;
                l1_hit_way = WAY_W'(w);
            end
        end
    end

    cache_victim_sel #(
        .WAYS  (L1_WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid  (l1_valid[l1_idx]),
        .ptr    (l1_ptr[l1_idx]),
        .victim (victim_way)
    );

    // ---------------------------------------------------------- write control
    // l1_alloc marks a victim fill (new line), which advances the pointer;
    // a store hitting L1 rewrites its way in place without touching it.
    logic              l1_we;
    logic              l1_alloc;
    logic [WAY_W-1:0]  l1_wr_way;
    logic [WORD_W-1:0] l1_wr_data;
    logic              l2_we;
    logic [WORD_W-1:0] l2_wr_data;

    always_comb begin
        l1_we      = 1'b0;
        l1_alloc   = 1'b0;
        l1_wr_way  = victim_way;
        l1_wr_data = '0;
        l2_we      = 1'b0;
        l2_wr_data = '0;
        unique case (state)
            S_IDLE: begin
                if (accept && req_write) begin
                    l1_we      = 1'b1;
                    l1_wr_data = req_wdata;
                    if (l1_hit) begin
                        l1_wr_way = l1_hit_way;
                    end else begin
                        l1_alloc = 1'b1;
                    end
                    l2_we      = 1'b1;
                    l2_wr_data = req_wdata;
                end
            end
            S_L2_LOOK: begin
                if (l2_hit) begin
                    l1_we      = 1'b1;
                    l1_alloc   = 1'b1;
                    l1_wr_data = l2_data[l2_idx];
                end
            end
            S_MEM_WAIT: begin
                // Stores already updated both levels when accepted.
                if (mem_resp_valid && !wr_q) begin
                    l1_we      = 1'b1;
                    l1_alloc   = 1'b1;
                    l1_wr_data = mem_resp_rdata;
                    l2_we      = 1'b1;
                    l2_wr_data = mem_resp_rdata;
                end
            end
            default: ;
        endcase
    end

    // NOTE: tag and data arrays carry no reset; the reset valid bits make
    // their contents irrelevant until a line is written.
    always_ff @(posedge clk) begin
        if (l1_we) begin
            l1_tag[l1_idx][l1_wr_way]  <= l1_tag_in;
            l1_data[l1_idx][l1_wr_way] <= l1_wr_data;
        end
        if (l2_we) begin
            l2_tag[l2_idx]  <= l2_tag_in;
            l2_data[l2_idx] <= l2_wr_data;
        end
    end

    // ------------------------------------------------------------------- FSM
    // NOTE: all state below is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            wr_q          <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_level    <= LVL_L1;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            l2_valid      <= '0;
            for (int s = 0; s < L1_SETS; s++) begin
                l1_valid[s] <= '0;
                l1_ptr[s]   <= '0;
            end
        end else begin
            resp_valid <= 1'b0;

            if (l1_we) begin
                l1_valid[l1_idx][l1_wr_way] <= 1'b1;
                if (l1_alloc) begin
                    l1_ptr[l1_idx] <= ptr_next;
                end
            end
            if (l2_we) begin
                l2_valid[l2_idx] <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    // flush forces req_ready low, so it never coincides with an accept.
                    if (flush) begin
                        for (int s = 0; s < L1_SETS; s++) begin
                            l1_valid[s] <= '0;
                            l1_ptr[s]   <= '0;
                        end
                    end else if (accept) begin
                        addr_q <= req_addr;
                        wr_q   <= req_write;
                        if (req_write) begin
                            state         <= S_MEM_WAIT;
                            mem_req_valid <= 1'b1;
                            mem_req_write <= 1'b1;
                            mem_req_addr  <= word_align(req_addr);
                            mem_req_wdata <= req_wdata;
                        end else if (l1_hit) begin
                            resp_valid <= 1'b1;
                            resp_level <= LVL_L1;
                            resp_rdata <= l1_data[l1_idx][l1_hit_way];
                        end else begin
                            state <= S_L2_LOOK;
                        end
                    end
                end
                S_L2_LOOK: begin
                    if (l2_hit) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b1;
                        resp_level <= LVL_L2;
                        resp_rdata <= l2_data[l2_idx];
                    end else begin
                        state         <= S_MEM_WAIT;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= word_align(addr_q);
                        mem_req_wdata <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        state         <= S_RESP;
                        mem_req_valid <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_level    <= LVL_MEM;
                        resp_rdata    <= wr_q ? '0 : mem_resp_rdata;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_EN
    // Counted on the response pulse, so each completed request counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_hit_cnt <= '0;
            l2_hit_cnt <= '0;
            miss_cnt   <= '0;
        end else if (resp_valid) begin
            case (resp_level)
                LVL_L1:  l1_hit_cnt <= l1_hit_cnt + 32'd1;
                LVL_L2:  l2_hit_cnt <= l2_hit_cnt + 32'd1;
                LVL_MEM: miss_cnt   <= miss_cnt + 32'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule
